mips_mc_control: RTL and testbench
==================================

# mips_mc_control

Multicycle main control unit for the 32-bit MIPS datapath; the producer side of the ALU control interface. Sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the 4-bit ALU operation code plus all datapath enables and mux selects. Stalls on a memory ready handshake and consumes the ALU zero flag for beq.

## Interface
Parameters:
- none. Opcodes, funct codes and ALU encodings are fixed constants in `mips_pkg`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0].
- `alu_zero`  in  1  1 when the ALU result equals 0.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `alu_control`  out  4  add 0010, sub 0110, and 0000, or 0001, nor 1100, slt 0111.
- `alu_src_a`  out  1  0=PC, 1=regA.
- `alu_src_b`  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `pc_write`, `pc_write_cond`, `pc_source[1:0]`  out  PC update controls; `pc_source` 00=ALU, 01=ALUOut, 10=jump target.
- `i_or_d`, `mem_read`, `mem_write`, `ir_write`  out  1 each  memory controls.
- `reg_write`, `reg_dst`, `mem_to_reg`  out  1 each  register file controls.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_control`=add. `ir_write`=`pc_write`=`mem_ready`. Holds until `mem_ready`=1, then goes to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, add (branch target). Dispatch on opcode:
  - 100011 lw / 101011 sw → MEM_ADDR.
  - 000000 → R_EXEC.
  - 001000 addi / 001100 andi / 001101 ori → I_EXEC.
  - 000100 → BRANCH.
  - 000010 → JUMP.
  - any other opcode → `illegal`=1, FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, add. Goes to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1. Holds until `mem_ready`, then FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00. Funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt. Any other funct → `illegal`=1, FETCH, and R_WB is skipped.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. `alu_control` holds the R_EXEC value.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=10; add/and/or per opcode. I_WB: `reg_write`=1, `reg_dst`=0.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_write_cond`=1, `pc_source`=01. The datapath ANDs `pc_write_cond` with `alu_zero`. Goes to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Goes to FETCH.
- Any signal not listed for a state is 0. `alu_control` defaults to add.

## Timing
- Outputs decode combinationally from the state register. `ir_write` and `pc_write` in FETCH also depend on `mem_ready` (Mealy).
- Reset (async, `rst_n`=0): state=FETCH immediately, so outputs take FETCH values with `mem_ready`=0: `mem_read`=1, `alu_control`=0010, all write enables 0, `illegal`=0.
- Reset mid-instruction aborts the instruction. No write enable may assert during reset.
- Cycle counts with zero wait states: lw 5, sw 4, R 4, I 4, beq 3, j 3, illegal 2.
- Each `mem_ready`=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle. `mem_ready` is ignored in all other states.
- `illegal` is asserted only for the single exit cycle, from DECODE or R_EXEC.

## Structure
- `mips_pkg`: opcode constants, funct constants, ALU encoding constants, state enum, `alu_src_b` / `pc_source` select encodings.
- Sub-module `mips_alu_decoder`: combinational (state class, opcode, funct) → `alu_control` + funct-valid flag. The FSM instantiates it once.

## Test plan
- Reset with `rst_n`=0 mid-MEM_WR → `mem_write` drops to 0 at once; FETCH outputs with `alu_control`=0010.
- R-type sub (funct 100010), `mem_ready`=1 → 4 cycles; R_EXEC `alu_control`=0110; `reg_write`=1 and `reg_dst`=1 only in cycle 4.
- lw with `mem_ready` low 3 cycles in MEM_RD → 8 cycles total; exactly one `reg_write` pulse, with `mem_to_reg`=1.
- beq with `alu_zero`=1, then with `alu_zero`=0 → BRANCH has `alu_control`=0110, `pc_write_cond`=1, `pc_source`=01; returns to FETCH after 3 cycles.
- opcode 111111 → `illegal` pulse in DECODE and FETCH next; R-type funct 000001 → `illegal` in R_EXEC and no `reg_write`.
- ori (001101) → I_EXEC `alu_control`=0001 and `alu_src_b`=10; I_WB `reg_write`=1, `reg_dst`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS main control unit.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned SEL_W   = 2;

  // Opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  // ALU operation encodings
  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;

  // alu_src_b selects
  localparam logic [SEL_W-1:0] SRC_B_REG    = 2'b00;
  localparam logic [SEL_W-1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] SRC_B_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] SRC_B_IMM_SH = 2'b11;

  // pc_source selects
  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_R_EXEC,
    ST_R_WB,
    ST_I_EXEC,
    ST_I_WB,
    ST_BRANCH,
    ST_JUMP
  } state_e;

  // How the ALU operation is chosen in the current state
  typedef enum logic [1:0] {
    ALU_CLS_ADD,
    ALU_CLS_SUB,
    ALU_CLS_RTYPE,
    ALU_CLS_ITYPE
  } alu_class_e;

  // True for the immediate-ALU opcodes handled by I_EXEC
  function automatic logic is_itype(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps (state class, opcode, funct) to the ALU operation and flags valid R-type functs.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  alu_class_e         cls,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALU_W-1:0]   alu_control,
  output logic               funct_valid
);

  // Funct validity is independent of state; only R_EXEC acts on it
  always_comb begin
    funct_valid = 1'b1;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: funct_valid = 1'b1;
      default:                                      funct_valid = 1'b0;
    endcase
  end

  // ALU operation select; unsupported codes fall back to add
  always_comb begin
    alu_control = ALU_ADD;
    case (cls)
      ALU_CLS_SUB: alu_control = ALU_SUB;
      ALU_CLS_RTYPE: begin
        case (funct)
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_NOR:  alu_control = ALU_NOR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      ALU_CLS_ITYPE: begin
        case (opcode)
          OP_ANDI: alu_control = ALU_AND;
          OP_ORI:  alu_control = ALU_OR;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
module mips_mc_control
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic [ALU_W-1:0]   alu_control,
  output logic               alu_src_a,
  output logic [SEL_W-1:0]   alu_src_b,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [SEL_W-1:0]   pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal
);

  state_e     state;
  state_e     state_next;
  alu_class_e alu_cls;
  logic       funct_valid;
  logic       fetch_done;

  // alu_zero is qualified with pc_write_cond inside the datapath
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  // Reset gating keeps the Mealy fetch enables low while rst_n is asserted
  assign fetch_done = mem_ready & rst_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_next;
  end

  // ALU operation class for the current state
  always_comb begin
    alu_cls = ALU_CLS_ADD;
    case (state)
      ST_R_EXEC, ST_R_WB: alu_cls = ALU_CLS_RTYPE;
      ST_I_EXEC:          alu_cls = ALU_CLS_ITYPE;
      ST_BRANCH:          alu_cls = ALU_CLS_SUB;
      default:            alu_cls = ALU_CLS_ADD;
    endcase
  end

  mips_alu_decoder u_alu_dec (
    .cls         (alu_cls),
    .opcode      (opcode),
    .funct       (funct),
    .alu_control (alu_control),
    .funct_valid (funct_valid)
  );

  // Next-state and datapath control decode
  always_comb begin
    state_next    = state;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PC_SRC_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = fetch_done;
        pc_write  = fetch_done;
        if (mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_b = SRC_B_IMM_SH;
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_next = ST_MEM_ADDR;
        else if (opcode == OP_RTYPE)                state_next = ST_R_EXEC;
        else if (is_itype(opcode))                  state_next = ST_I_EXEC;
        else if (opcode == OP_BEQ)                  state_next = ST_BRANCH;
        else if (opcode == OP_J)                    state_next = ST_JUMP;
        else begin
          illegal    = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_next = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_next = ST_FETCH;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        if (funct_valid) state_next = ST_R_WB;
        else begin
          illegal    = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = ST_FETCH;
      end
      ST_I_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRC_B_IMM;
        state_next = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write  = 1'b1;
        state_next = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
        state_next    = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PC_SRC_JUMP;
        state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed self-checking bench for mips_mc_control, cycle-by-cycle control vectors.
module tb_mips_mc_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       mem_ready;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;

  typedef struct packed {
    logic [3:0] alu;
    logic       src_a;
    logic [1:0] src_b;
    logic       pc_wr;
    logic       pc_wr_cond;
    logic [1:0] pc_src;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rwr;
    logic       rdst;
    logic       m2r;
    logic       ill;
  } ctl_t;

  typedef enum {T_FETCH, T_DECODE, T_MEM_ADDR, T_MEM_RD, T_MEM_WB, T_MEM_WR,
                T_R_EXEC, T_R_WB, T_I_EXEC, T_I_WB, T_BRANCH, T_JUMP} tst_e;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SLT = 4'b0111;
  localparam logic [3:0] A_NOR = 4'b1100;

  int checks   = 0;
  int failures = 0;
  ctl_t sb[$];

  mips_mc_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct         (funct),
    .alu_zero      (alu_zero),
    .mem_ready     (mem_ready),
    .alu_control   (alu_control),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .illegal       (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected control vector for a state, built from the per-state output table
  function automatic ctl_t model(input tst_e st, input logic mr, input logic [3:0] alu,
                                 input logic ill);
    ctl_t c;
    c     = '0;
    c.alu = A_ADD;
    case (st)
      T_FETCH:    begin c.mrd = 1'b1; c.src_b = 2'b01; c.irw = mr; c.pc_wr = mr; end
      T_DECODE:   begin c.src_b = 2'b11; c.ill = ill; end
      T_MEM_ADDR: begin c.src_a = 1'b1; c.src_b = 2'b10; end
      T_MEM_RD:   begin c.mrd = 1'b1; c.iord = 1'b1; end
      T_MEM_WB:   begin c.rwr = 1'b1; c.m2r = 1'b1; end
      T_MEM_WR:   begin c.mwr = 1'b1; c.iord = 1'b1; end
      T_R_EXEC:   begin c.src_a = 1'b1; c.alu = alu; c.ill = ill; end
      T_R_WB:     begin c.rwr = 1'b1; c.rdst = 1'b1; c.alu = alu; end
      T_I_EXEC:   begin c.src_a = 1'b1; c.src_b = 2'b10; c.alu = alu; end
      T_I_WB:     begin c.rwr = 1'b1; end
      T_BRANCH:   begin c.src_a = 1'b1; c.alu = A_SUB; c.pc_wr_cond = 1'b1; c.pc_src = 2'b01; end
      T_JUMP:     begin c.pc_wr = 1'b1; c.pc_src = 2'b10; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t observed();
    return '{alu: alu_control, src_a: alu_src_a, src_b: alu_src_b, pc_wr: pc_write,
             pc_wr_cond: pc_write_cond, pc_src: pc_source, iord: i_or_d, mrd: mem_read,
             mwr: mem_write, irw: ir_write, rwr: reg_write, rdst: reg_dst,
             m2r: mem_to_reg, ill: illegal};
  endfunction

  task automatic check_pop(input string tag);
    ctl_t exp;
    ctl_t got;
    exp = sb.pop_front();
    got = observed();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive mem_ready, queue expectation, sample mid-cycle, advance
  task automatic step(input tst_e st, input logic mr, input logic [3:0] alu,
                      input logic ill, input string tag);
    mem_ready = mr;
    sb.push_back(model(st, mr, alu, ill));
    #1;
    check_pop(tag);
    @(negedge clk);
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  logic [5:0] r_fn  [5];
  logic [3:0] r_alu [5];

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'b000000;
    funct     = 6'b000000;
    alu_zero  = 1'b0;
    mem_ready = 1'b1;
    // Reset with mem_ready high: FETCH outputs but no write enable
    sb.push_back(model(T_FETCH, 1'b0, A_ADD, 1'b0));
    #1;
    check_pop("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;

    // R-type sub, zero wait states: 4 cycles
    set_ir(6'b000000, 6'b100010);
    step(T_FETCH,  1'b1, A_ADD, 1'b0, "sub_fetch");
    step(T_DECODE, 1'b0, A_ADD, 1'b0, "sub_decode");
    step(T_R_EXEC, 1'b0, A_SUB, 1'b0, "sub_rexec");
    step(T_R_WB,   1'b0, A_SUB, 1'b0, "sub_rwb");

    // lw with three mem_ready-low cycles in MEM_RD: 8 cycles
    set_ir(6'b100011, 6'b000000);
    step(T_FETCH,    1'b1, A_ADD, 1'b0, "lw_fetch");
    step(T_DECODE,   1'b1, A_ADD, 1'b0, "lw_decode");
    step(T_MEM_ADDR, 1'b0, A_ADD, 1'b0, "lw_addr");
    step(T_MEM_RD,   1'b0, A_ADD, 1'b0, "lw_rd_wait0");
    step(T_MEM_RD,   1'b0, A_ADD, 1'b0, "lw_rd_wait1");
    step(T_MEM_RD,   1'b0, A_ADD, 1'b0, "lw_rd_wait2");
    step(T_MEM_RD,   1'b1, A_ADD, 1'b0, "lw_rd_done");
    step(T_MEM_WB,   1'b0, A_ADD, 1'b0, "lw_wb");

    // beq taken then not taken: identical control, 3 cycles each
    set_ir(6'b000100, 6'b000000);
    alu_zero = 1'b1;
    step(T_FETCH,  1'b1, A_ADD, 1'b0, "beq1_fetch");
    step(T_DECODE, 1'b0, A_ADD, 1'b0, "beq1_decode");
    step(T_BRANCH, 1'b0, A_ADD, 1'b0, "beq1_branch");
    alu_zero = 1'b0;
    step(T_FETCH,  1'b1, A_ADD, 1'b0, "beq0_fetch");
    step(T_DECODE, 1'b1, A_ADD, 1'b0, "beq0_decode");
    step(T_BRANCH, 1'b1, A_ADD, 1'b0, "beq0_branch");

    // jump with a one-cycle fetch stall
    set_ir(6'b000010, 6'b000000);
    step(T_FETCH,  1'b0, A_ADD, 1'b0, "j_fetch_stall");
    step(T_FETCH,  1'b1, A_ADD, 1'b0, "j_fetch");
    step(T_DECODE, 1'b0, A_ADD, 1'b0, "j_decode");
    step(T_JUMP,   1'b0, A_ADD, 1'b0, "j_jump");

    // Unsupported opcode: illegal pulse in DECODE then FETCH
    set_ir(6'b111111, 6'b100000);
    step(T_FETCH,  1'b1, A_ADD, 1'b0, "badop_fetch");
    step(T_DECODE, 1'b1, A_ADD, 1'b1, "badop_decode");

    // Unsupported funct: illegal in R_EXEC, no writeback
    set_ir(6'b000000, 6'b000001);
    step(T_FETCH,  1'b1, A_ADD, 1'b0, "badfn_fetch");
    step(T_DECODE, 1'b0, A_ADD, 1'b0, "badfn_decode");
    step(T_R_EXEC, 1'b0, A_ADD, 1'b1, "badfn_rexec");

    // ori, andi, addi through I_EXEC / I_WB
    set_ir(6'b001101, 6'b000000);
    step(T_FETCH,  1'b1, A_ADD, 1'b0, "ori_fetch");
    step(T_DECODE, 1'b0, A_ADD, 1'b0, "ori_decode");
    step(T_I_EXEC, 1'b0, A_OR,  1'b0, "ori_iexec");
    step(T_I_WB,   1'b0, A_ADD, 1'b0, "ori_iwb");
    set_ir(6'b001100, 6'b000000);
    step(T_FETCH,  1'b1, A_ADD, 1'b0, "andi_fetch");
    step(T_DECODE, 1'b0, A_ADD, 1'b0, "andi_decode");
    step(T_I_EXEC, 1'b0, A_AND, 1'b0, "andi_iexec");
    step(T_I_WB,   1'b0, A_ADD, 1'b0, "andi_iwb");
    set_ir(6'b001000, 6'b000000);
    step(T_FETCH,  1'b1, A_ADD, 1'b0, "addi_fetch");
    step(T_DECODE, 1'b0, A_ADD, 1'b0, "addi_decode");
    step(T_I_EXEC, 1'b0, A_ADD, 1'b0, "addi_iexec");
    step(T_I_WB,   1'b0, A_ADD, 1'b0, "addi_iwb");

    // Remaining R-type functs
    r_fn[0] = 6'b100000; r_alu[0] = A_ADD;
    r_fn[1] = 6'b100100; r_alu[1] = A_AND;
    r_fn[2] = 6'b100101; r_alu[2] = A_OR;
    r_fn[3] = 6'b100111; r_alu[3] = A_NOR;
    r_fn[4] = 6'b101010; r_alu[4] = A_SLT;
    for (int i = 0; i < 5; i++) begin
      set_ir(6'b000000, r_fn[i]);
      step(T_FETCH,  1'b1, A_ADD,    1'b0, $sformatf("r%0d_fetch", i));
      step(T_DECODE, 1'b0, A_ADD,    1'b0, $sformatf("r%0d_decode", i));
      step(T_R_EXEC, 1'b1, r_alu[i], 1'b0, $sformatf("r%0d_rexec", i));
      step(T_R_WB,   1'b0, r_alu[i], 1'b0, $sformatf("r%0d_rwb", i));
    end

    // sw completes normally: 4 cycles
    set_ir(6'b101011, 6'b000000);
    step(T_FETCH,    1'b1, A_ADD, 1'b0, "sw_fetch");
    step(T_DECODE,   1'b0, A_ADD, 1'b0, "sw_decode");
    step(T_MEM_ADDR, 1'b0, A_ADD, 1'b0, "sw_addr");
    step(T_MEM_WR,   1'b1, A_ADD, 1'b0, "sw_wr");

    // sw stalled in MEM_WR, then aborted by reset mid-cycle
    step(T_FETCH,    1'b1, A_ADD, 1'b0, "swr_fetch");
    step(T_DECODE,   1'b0, A_ADD, 1'b0, "swr_decode");
    step(T_MEM_ADDR, 1'b0, A_ADD, 1'b0, "swr_addr");
    step(T_MEM_WR,   1'b0, A_ADD, 1'b0, "swr_wr_wait");
    mem_ready = 1'b0;
    sb.push_back(model(T_MEM_WR, 1'b0, A_ADD, 1'b0));
    #1;
    check_pop("swr_wr_hold");
    #1;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    sb.push_back(model(T_FETCH, 1'b0, A_ADD, 1'b0));
    #1;
    check_pop("swr_reset_abort");
    @(negedge clk);
    sb.push_back(model(T_FETCH, 1'b0, A_ADD, 1'b0));
    check_pop("swr_reset_held");
    rst_n = 1'b1;
    step(T_FETCH,    1'b1, A_ADD, 1'b0, "post_reset_fetch");
    step(T_DECODE,   1'b0, A_ADD, 1'b0, "post_reset_decode");
    step(T_MEM_ADDR, 1'b0, A_ADD, 1'b0, "post_reset_addr");
    step(T_MEM_WR,   1'b1, A_ADD, 1'b0, "post_reset_wr");
    step(T_FETCH,    1'b0, A_ADD, 1'b0, "final_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
